// File: rtl/sdram_req_arbiter_if.sv
// sdram_req_arbiter_if: requester, sdram_system and response signals of the request arbiter
interface sdram_req_arbiter_if #(parameter int NUM_REQ = 3);
  logic [NUM_REQ-1:0]    s_axis_req_tvalid;
  logic [NUM_REQ-1:0]    s_axis_req_tready;
  logic [NUM_REQ*64-1:0] s_axis_req_tdata;
  logic                  m_axis_sdram_req_tvalid;
  logic                  m_axis_sdram_req_tready;
  logic [63:0]           m_axis_sdram_req_tdata;
  logic                  s_axis_sdram_res_tvalid;
  logic [31:0]           s_axis_sdram_res_tdata;
  logic [NUM_REQ-1:0]    m_axis_res_tvalid;
  logic [31:0]           m_axis_res_tdata;
  logic                  orphan_err;
  modport slave (
    input  s_axis_req_tvalid, s_axis_req_tdata, m_axis_sdram_req_tready,
           s_axis_sdram_res_tvalid, s_axis_sdram_res_tdata,
    output s_axis_req_tready, m_axis_sdram_req_tvalid, m_axis_sdram_req_tdata,
           m_axis_res_tvalid, m_axis_res_tdata, orphan_err
  );
  modport master (
    output s_axis_req_tvalid, s_axis_req_tdata, m_axis_sdram_req_tready,
           s_axis_sdram_res_tvalid, s_axis_sdram_res_tdata,
    input  s_axis_req_tready, m_axis_sdram_req_tvalid, m_axis_sdram_req_tdata,
           m_axis_res_tvalid, m_axis_res_tdata, orphan_err
  );
endinterface

// File: rtl/sdram_req_arbiter.sv
// sdram_req_arbiter: round-robin sharing of the sdram_system port with in-order response routing.
// Define SDRAM_ARB_PRIO0_EN to give requester 0 absolute priority.
module sdram_req_arbiter #(
  parameter int NUM_REQ   = 3,
  parameter int TAG_DEPTH = 8
) (
  input logic clk,
  input logic reset,
  sdram_req_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int AW = TAG_DEPTH > 1 ? $clog2(TAG_DEPTH) : 1;
  logic [IW-1:0]      rr, win, rr_nx;
  logic [IW:0]        idx;
  logic [NUM_REQ-1:0] elig;
  logic [63:0]        win_data;
  logic               found, full, slot_free, grant, push, pop, rr_upd;
  logic [IW-1:0]      tags [TAG_DEPTH];
  logic [AW-1:0]      wp, rp;
  logic [AW:0]        cnt;
  always_comb begin
    full = cnt == (AW+1)'(TAG_DEPTH);
    for (int i = 0; i < NUM_REQ; i++)
      elig[i] = bus.s_axis_req_tvalid[i] && (bus.s_axis_req_tdata[64*i+63] || !full);
    win = '0;
    found = 1'b0;
    idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (IW+1)'(rr) + (IW+1)'(k);
      if (idx >= (IW+1)'(NUM_REQ)) idx = idx - (IW+1)'(NUM_REQ);
      if (!found && elig[idx[IW-1:0]]) begin
        win = idx[IW-1:0];
        found = 1'b1;
      end
    end
`ifdef SDRAM_ARB_PRIO0_EN
    if (elig[0]) win = '0;
`endif
    slot_free = !bus.m_axis_sdram_req_tvalid || bus.m_axis_sdram_req_tready;
    grant = !reset && slot_free && found;
    win_data = bus.s_axis_req_tdata[64*win +: 64];
    // the full check above uses the pre-pop count, so a same-cycle pop cannot admit a read
    push = grant && !win_data[63];
    pop = bus.s_axis_sdram_res_tvalid && cnt != '0;
    bus.s_axis_req_tready = grant ? NUM_REQ'(1) << win : '0;
`ifdef SDRAM_ARB_PRIO0_EN
    rr_upd = grant && win != '0;
`else
    rr_upd = grant;
`endif
    rr_nx = win == IW'(NUM_REQ-1) ? '0 : win + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.m_axis_sdram_req_tvalid <= 1'b0;
      bus.m_axis_sdram_req_tdata  <= '0;
      bus.m_axis_res_tvalid       <= '0;
      bus.m_axis_res_tdata        <= '0;
      bus.orphan_err              <= 1'b0;
      rr  <= '0;
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (grant) begin
        bus.m_axis_sdram_req_tvalid <= 1'b1;
        bus.m_axis_sdram_req_tdata  <= win_data;
      end else if (bus.m_axis_sdram_req_tready) begin
        bus.m_axis_sdram_req_tvalid <= 1'b0;
      end
      if (rr_upd) rr <= rr_nx;
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
      bus.m_axis_res_tvalid <= pop ? NUM_REQ'(1) << tags[rp] : '0;
      if (pop) bus.m_axis_res_tdata <= bus.s_axis_sdram_res_tdata;
      bus.orphan_err <= bus.orphan_err || (bus.s_axis_sdram_res_tvalid && cnt == '0);
    end
  end
  always_ff @(posedge clk) if (push) tags[wp] <= win;
endmodule
